// File: rtl/spi_slave_if_pkg.sv
// Shared SPI definitions: mode/cmd bit positions, default fill byte, state type.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package spi_slave_if_pkg;

  // Bit positions inside a settings write (din on cmd)
  localparam int CMD_CPHA = 0;
  localparam int CMD_CPOL = 1;
  localparam int CMD_LSB  = 2;
  localparam int CMD_CLR  = 3;

  // Byte returned to the master when nothing has been queued
  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Reverse bit order of a byte (used for LSB-first framing)
  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Oversamples sck/ss/mosi into clk and emits single-cycle leading/trailing/ss edge pulses.
// Latency: pulses are high in the 3rd clk after a pin change; state acting on them updates on that edge.
// Backpressure: none; pins are sampled every clk.
module spi_slave_sync (
  input  logic clk,
  input  logic rst,
  input  logic cpol,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic lead,
  output logic trail,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  // Two sync flops per pin plus a third stage on sck/ss for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[1:0], ss};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // mosi stage 2 lines up with sck stage 2, so it is the bit present at the edge
  assign mosi_s  = mosi_q[1];
  assign lead    = (sck_q[1] != cpol) && (sck_q[2] == cpol);
  assign trail   = (sck_q[1] == cpol) && (sck_q[2] != cpol);
  assign ss_fall = !ss_q[1] && ss_q[2];
  assign ss_rise = ss_q[1] && !ss_q[2];

endmodule

// File: rtl/srl_fifo.sv
// Generic synchronous FIFO, power-of-2 depth, combinational read of the head entry.
// Latency: push visible at head one clk later; pop_dat valid whenever !empty.
// Backpressure: push ignored when full, pop ignored when empty; push+pop in one cycle both honoured.
module srl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_dat = mem[rptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array, no reset needed: contents are only read when counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI target: oversampled pins, TX FIFO feeds miso, RX FIFO collects mosi bytes; all CPOL/CPHA, MSB/LSB.
// Latency: SPI pin to internal action 3 clk; bus ack 1 clk after wr/rd/cmd; dout combinational on rd.
// Backpressure: wr dropped (not acked) when TX full; RX byte dropped and ovr set when RX full.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] FILL  = FILL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       cmd,
  input  logic       wr,
  input  logic       rd,
  output logic [8:0] dout,
  output logic       ack,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       busy,
  output logic       ovr,
  output logic       udr
);

  state_t     state;
  logic       cpol, cpha, lsb;
  logic       oe_q;
  logic [2:0] cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;

  logic       lead, trail, ss_fall, ss_rise, mosi_s;
  logic       active, shift_edge, sample_edge;
  logic       tx_load, rx_push, clr;
  logic [7:0] rx_byte, tx_byte, tx_ord;
  logic       tx_push, tx_empty, tx_full;
  logic       rx_pop, rx_empty, rx_full;
  logic [7:0] tx_pop_dat, rx_pop_dat;

  spi_slave_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .cpol    (cpol),
    .sck     (spi_sck),
    .ss      (spi_ss),
    .mosi    (spi_mosi),
    .lead    (lead),
    .trail   (trail),
    .ss_fall (ss_fall),
    .ss_rise (ss_rise),
    .mosi_s  (mosi_s)
  );

  // A deselect wins over any sck edge seen in the same cycle
  assign active      = (state == ST_ACTIVE) && !ss_rise;
  assign shift_edge  = cpha ? lead : trail;
  assign sample_edge = cpha ? trail : lead;
  // CPHA=0 preloads at select; afterwards both modes load at the first shift edge of a byte
  assign tx_load     = ((state == ST_IDLE) && ss_fall && !cpha) ||
                       (active && shift_edge && (cnt == 3'd0));
  assign rx_push     = active && sample_edge && (cnt == 3'd7);
  assign rx_byte     = lsb ? bit_rev({rx_sr, mosi_s}) : {rx_sr, mosi_s};
  assign tx_byte     = tx_empty ? FILL : tx_pop_dat;
  assign tx_ord      = lsb ? bit_rev(tx_byte) : tx_byte;
  assign tx_push     = wr && !tx_full;
  assign rx_pop      = rd && !rx_empty;
  assign clr         = cmd && din[CMD_CLR];
  assign dout        = rx_pop ? {1'b0, rx_pop_dat} : {1'b1, 8'h00};
  assign spi_miso_oe = oe_q && !ss_rise;

  srl_fifo #(.W(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_dat (din),
    .pop      (tx_load),
    .pop_dat  (tx_pop_dat),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  srl_fifo #(.W(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_dat (rx_byte),
    .pop      (rx_pop),
    .pop_dat  (rx_pop_dat),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  // Select FSM plus bit counter, RX shifter and TX shifter driving miso
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      oe_q     <= 1'b0;
      cnt      <= 3'd0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state <= ST_ACTIVE;
            busy  <= 1'b1;
            oe_q  <= 1'b1;
            cnt   <= 3'd0;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            oe_q  <= 1'b0;
            cnt   <= 3'd0;
            rx_sr <= '0;
          end else if (sample_edge) begin
            rx_sr <= {rx_sr[5:0], mosi_s};
            cnt   <= cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (tx_load) begin
        spi_miso <= tx_ord[7];
        tx_sr    <= tx_ord[6:0];
      end else if (active && shift_edge) begin
        spi_miso <= tx_sr[6];
        tx_sr    <= {tx_sr[5:0], 1'b0};
      end
    end
  end

  // Settings (frozen while selected), sticky flags and bus acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
      lsb  <= 1'b0;
      ovr  <= 1'b0;
      udr  <= 1'b0;
      ack  <= 1'b0;
    end else begin
      ack <= tx_push || rd || cmd;
      if (cmd && (state == ST_IDLE)) begin
        cpol <= din[CMD_CPOL];
        cpha <= din[CMD_CPHA];
        lsb  <= din[CMD_LSB];
      end
      ovr <= (rx_push && rx_full) || (ovr && !clr);
      udr <= (tx_load && tx_empty) || (udr && !clr);
    end
  end

endmodule
